// File: rtl/pipe_credit_adapter.sv
// Credit-throttled valid/ready wrapper around a fixed-latency, non-stalling pipeline.
// Define PIPE_CREDIT_ADAPTER_ERR_EN to build the sticky protocol-violation flag on err.
module pipe_credit_adapter #(
    parameter int width   = 8,
    parameter int latency = 5,
    parameter int depth   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld,
    output logic             up_rdy,
    input  logic [width-1:0] up_data,
    output logic             pipe_vld,
    output logic [width-1:0] pipe_data,
    input  logic             pipe_res_vld,
    input  logic [width-1:0] pipe_res_data,
    output logic             down_vld,
    input  logic             down_rdy,
    output logic [width-1:0] down_data,
    output logic             err
);

    localparam int CW = $clog2(depth + 1);
    localparam int PW = $clog2(depth);
    localparam logic [CW:0]   DEPTH_S = (CW + 1)'(depth);
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [PW-1:0] LAST    = PW'(depth - 1);

    if (latency < 1 || depth < 2) begin : g_bad_cfg
        $error("pipe_credit_adapter: need latency >= 1 and depth >= 2");
    end

    logic [CW-1:0]    in_flight;
    logic [CW-1:0]    count;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [width-1:0] mem [depth];

    logic acc;
    logic push;
    logic pop;
    logic ret;

    // Credits = results still in the pipe plus results parked in the FIFO.
    assign up_rdy = ({1'b0, in_flight} + {1'b0, count}) < DEPTH_S;
    assign acc    = up_vld & up_rdy;

    assign pipe_vld  = acc;
    assign pipe_data = up_data;

    assign down_vld  = count != '0;
    assign down_data = mem[rd_ptr];
    assign pop       = down_vld & down_rdy;

    // A same-cycle pop frees the slot a full FIFO needs for this push.
    assign push = pipe_res_vld & ((count < DEPTH_C) | pop);
    assign ret  = pipe_res_vld & (in_flight != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_flight <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            in_flight <= in_flight + CW'(acc) - CW'(ret);
            count     <= count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pipe_res_data;
        end
    end

`ifdef PIPE_CREDIT_ADAPTER_ERR_EN
    logic err_q;
    logic viol;

    assign viol = (pipe_res_vld & ~push) | (pipe_res_vld & (in_flight == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (viol) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_credit_adapter.sv
// Bench for pipe_credit_adapter: x^5 mod 256 pipeline stub, credit/order scoreboard.
// Scenario tasks add inline checks; a negedge monitor checks every cycle.
module tb_pipe_credit_adapter;

    localparam int W = 8;
    localparam int L = 5;
    localparam int D = 6;

`ifdef PIPE_CREDIT_ADAPTER_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         up_vld = 1'b0;
    logic         up_rdy;
    logic [W-1:0] up_data = '0;
    logic         pipe_vld;
    logic [W-1:0] pipe_data;
    logic         pipe_res_vld;
    logic [W-1:0] pipe_res_data;
    logic         down_vld;
    logic         down_rdy = 1'b0;
    logic [W-1:0] down_data;
    logic         err;

    logic         inj_vld = 1'b0;
    logic [W-1:0] inj_data = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int npop = 0;
    int outstanding = 0;
    bit mon_en = 1'b1;

    typedef struct {
        logic [W-1:0] data;
        int           rc;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    pipe_credit_adapter #(.width(W), .latency(L), .depth(D)) dut (
        .clk(clk),
        .rst(rst),
        .up_vld(up_vld),
        .up_rdy(up_rdy),
        .up_data(up_data),
        .pipe_vld(pipe_vld),
        .pipe_data(pipe_data),
        .pipe_res_vld(pipe_res_vld),
        .pipe_res_data(pipe_res_data),
        .down_vld(down_vld),
        .down_rdy(down_rdy),
        .down_data(down_data),
        .err(err)
    );

    function automatic logic [W-1:0] pow5(input logic [W-1:0] x);
        longint unsigned p;
        p = longint'(x) * x * x * x * x;
        return W'(p % 256);
    endfunction

    // Fixed-latency pipeline stub sharing the adapter's reset
    logic [L-1:0] pv;
    logic [W-1:0] pd [L];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[L-2:0], pipe_vld};
            pd[0] <= pow5(pipe_data);
            for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
        end
    end

    assign pipe_res_vld  = pv[L-1] | inj_vld;
    assign pipe_res_data = inj_vld ? inj_data : pd[L-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: credits held from accept until pop, results due latency+1 after accept
    always @(negedge clk) begin
        logic exp_rdy;
        logic exp_dv;
        if (!rst) begin
            q.delete();
            outstanding = 0;
            n_checks++;
            if (up_rdy !== 1'b1 || down_vld !== 1'b0 || err !== 1'b0 || pipe_vld !== up_vld) begin
                n_errors++;
                $display("FAIL rst_outputs: got rdy=%b dv=%b err=%b pv=%b, want 1 0 0 %b",
                         up_rdy, down_vld, err, pipe_vld, up_vld);
            end
        end else if (mon_en) begin
            exp_rdy = outstanding < D;
            exp_dv  = (q.size() > 0) && (q[0].rc <= cyc);
            n_checks++;
            if (up_rdy !== exp_rdy) begin
                n_errors++;
                $display("FAIL mon_up_rdy cyc=%0d: got %b want %b", cyc, up_rdy, exp_rdy);
            end
            n_checks++;
            if (pipe_vld !== (up_vld & exp_rdy) || (pipe_vld && pipe_data !== up_data)) begin
                n_errors++;
                $display("FAIL mon_issue cyc=%0d: got vld=%b data=%0d want vld=%b data=%0d",
                         cyc, pipe_vld, pipe_data, up_vld & exp_rdy, up_data);
            end
            n_checks++;
            if (down_vld !== exp_dv) begin
                n_errors++;
                $display("FAIL mon_down_vld cyc=%0d: got %b want %b", cyc, down_vld, exp_dv);
            end
            if (down_vld && down_rdy && q.size() > 0) begin
                n_checks++;
                if (down_data !== q[0].data) begin
                    n_errors++;
                    $display("FAIL mon_down_data cyc=%0d: got %0d want %0d",
                             cyc, down_data, q[0].data);
                end
                void'(q.pop_front());
                npop++;
            end
            if (up_vld && up_rdy) q.push_back('{pow5(up_data), cyc + L + 1});
            outstanding += int'(up_vld & up_rdy) - int'(down_vld & down_rdy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (up_rdy !== 1'b1 || down_vld !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: got rdy=%b dv=%b err=%b want 1 0 0", up_rdy, down_vld, err);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (up_rdy !== 1'b1 || down_vld !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got rdy=%b dv=%b err=%b want 1 0 0", up_rdy, down_vld, err);
        end
        tick();
    endtask

    task automatic test_single();
        up_vld   = 1'b1;
        up_data  = 8'd3;
        down_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pipe_vld !== 1'b1 || pipe_data !== 8'd3) begin
            n_errors++;
            $display("FAIL single_issue: got vld=%b data=%0d want 1 3", pipe_vld, pipe_data);
        end
        tick();
        up_vld = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) begin
                n_checks++;
                if (down_vld !== 1'b0) begin
                    n_errors++;
                    $display("FAIL single_early: got down_vld=%b want 0", down_vld);
                end
            end
            if (k == 6) begin
                n_checks++;
                if (down_vld !== 1'b1 || down_data !== 8'd243) begin
                    n_errors++;
                    $display("FAIL single_result: got vld=%b data=%0d want 1 243", down_vld, down_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        int sent;
        p0   = npop;
        sent = 0;
        down_rdy = 1'b1;
        for (int c = 0; c < 40 && sent < 20; c++) begin
            up_vld  = 1'b1;
            up_data = W'(sent);
            @(negedge clk);
            if (up_rdy) sent++;
            tick();
        end
        up_vld = 1'b0;
        n_checks++;
        if (sent != 20) begin
            n_errors++;
            $display("FAIL b2b_sent: got %0d want 20", sent);
        end
        repeat (12) tick();
        n_checks++;
        if (npop - p0 != 20 || q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_results: got %0d pops, %0d left, want 20, 0", npop - p0, q.size());
        end
    endtask

    task automatic test_stall();
        int accepted;
        accepted = 0;
        down_rdy = 1'b0;
        up_vld   = 1'b1;
        up_data  = 8'd2;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (up_rdy) accepted++;
            tick();
        end
        n_checks++;
        if (accepted != D) begin
            n_errors++;
            $display("FAIL stall_accepts: got %0d want %0d", accepted, D);
        end
        down_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (up_rdy !== 1'b0 || down_vld !== 1'b1 || down_data !== 8'd32) begin
            n_errors++;
            $display("FAIL stall_pop: got rdy=%b dv=%b data=%0d want 0 1 32", up_rdy, down_vld, down_data);
        end
        tick();
        down_rdy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (up_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_credit_back: got up_rdy=%b want 1", up_rdy);
        end
        tick();
        up_vld   = 1'b0;
        down_rdy = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_mid_reset();
        down_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            up_vld  = 1'b1;
            up_data = W'(i + 5);
            @(negedge clk);
            tick();
        end
        up_vld = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (down_vld !== 1'b1 || down_data !== pow5(8'd5)) begin
            n_errors++;
            $display("FAIL midrst_before: got dv=%b data=%0d want 1 %0d", down_vld, down_data, pow5(8'd5));
        end
        #1 rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (down_vld !== 1'b0 || up_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_after: got dv=%b rdy=%b want 0 1", down_vld, up_rdy);
        end
        tick();
        down_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (down_vld !== 1'b0) begin
                n_errors++;
                $display("FAIL midrst_stale: cyc %0d got down_vld=%b want 0", c, down_vld);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            up_vld   = ($urandom % 4) != 0;
            up_data  = W'($urandom);
            down_rdy = ($urandom % 3) != 0;
            tick();
        end
        up_vld   = 1'b0;
        down_rdy = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        n_checks++;
        if (q.size() != 0 || down_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL random_drain: got %0d left dv=%b want 0 0", q.size(), down_vld);
        end
        tick();
    endtask

    task automatic test_err();
        mon_en   = 1'b0;
        down_rdy = 1'b1;
        inj_vld  = 1'b1;
        inj_data = 8'hA5;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_same_cycle: got %b want 0", err);
        end
        tick();
        inj_vld = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err !== ERR_EXP) begin
            n_errors++;
            $display("FAIL err_set: got %b want %b", err, ERR_EXP);
        end
        n_checks++;
        if (down_vld !== 1'b1 || down_data !== 8'hA5) begin
            n_errors++;
            $display("FAIL err_orphan_push: got dv=%b data=%0h want 1 a5", down_vld, down_data);
        end
        tick();
        repeat (5) tick();
        @(negedge clk);
        n_checks++;
        if (err !== ERR_EXP) begin
            n_errors++;
            $display("FAIL err_sticky: got %b want %b", err, ERR_EXP);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_clear: got %b want 0", err);
        end
        tick();
        rst    = 1'b1;
        mon_en = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_random();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
